// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM states,
// instruction word width and the bubble instruction shown while the buffer is empty.
package ifetch_unit_pkg;

  localparam int WORD_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [WORD_WIDTH-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_REQ  = 2'd0,
    IF_WAIT = 2'd1,
    IF_DROP = 2'd2
  } ifState_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO holding fetched {instruction, pc} pairs; flush empties it in one cycle.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] pushData,
  output logic [WIDTH-1:0] headData,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPop    = pop && !empty;
  // A write into a full buffer is legal when the head leaves in the same cycle
  assign doPush   = push && (!full || doPop);
  assign headData = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !rst && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over req/gnt/rvalid, buffers results.
// Define IFETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counters.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [WORD_WIDTH-1:0] imem_rdata,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_pc4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int ENTRY_W = WORD_WIDTH + ADDR_WIDTH;

  ifState_t              state;
  ifState_t              nextState;
  logic [ADDR_WIDTH-1:0] fetchPc;
  logic [ADDR_WIDTH-1:0] nextFetchPc;
  logic [ADDR_WIDTH-1:0] pendPc;
  logic                  pushEn;
  logic                  flushEn;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  popFire;
  logic                  grantFire;
  logic                  canIssue;
  logic [ENTRY_W-1:0]    headData;
  logic [WORD_WIDTH-1:0] headInstr;
  logic [ADDR_WIDTH-1:0] headPc;

  ifetch_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) uFifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pushEn),
    .pop      (popFire),
    .flush    (flushEn),
    .pushData ({imem_rdata, pendPc}),
    .headData (headData),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign {headInstr, headPc} = headData;

  assign out_valid = !fifoEmpty && !rst;
  assign out_pc    = headPc;
  assign out_pc4   = headPc + ADDR_WIDTH'(4);
  assign out_instr = out_valid ? headInstr : INSTR_NOP;
  assign popFire   = out_valid && out_ready;

  // A pop in this cycle frees a slot, so a full buffer may request immediately
  assign canIssue  = !fifoFull || popFire;
  assign imem_req  = (state == IF_REQ) && canIssue && !rst;
  assign imem_addr = fetchPc;
  assign grantFire = imem_req && imem_gnt;

  // A redirect flushes the buffer and steers the FSM toward dropping any response
  // still owed by memory; if that response arrives in the redirect cycle itself it
  // is swallowed immediately and the FSM goes straight back to requesting.
  always_comb begin
    nextState   = state;
    nextFetchPc = fetchPc;
    pushEn      = 1'b0;
    flushEn     = 1'b0;
    if (redirect_valid) begin
      flushEn     = 1'b1;
      nextFetchPc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      case (state)
        IF_REQ:           nextState = grantFire ? IF_DROP : IF_REQ;
        IF_WAIT, IF_DROP: nextState = imem_rvalid ? IF_REQ : IF_DROP;
        default:          nextState = IF_REQ;
      endcase
    end else begin
      case (state)
        IF_REQ: begin
          if (grantFire) begin
            nextState   = IF_WAIT;
            nextFetchPc = fetchPc + ADDR_WIDTH'(4);
          end
        end
        IF_WAIT: begin
          if (imem_rvalid) begin
            pushEn    = 1'b1;
            nextState = IF_REQ;
          end
        end
        IF_DROP: begin
          if (imem_rvalid) nextState = IF_REQ;
        end
        default: nextState = IF_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IF_REQ;
      fetchPc <= RESET_PC;
      pendPc  <= RESET_PC;
    end else begin
      state   <= nextState;
      fetchPc <= nextFetchPc;
      if (grantFire) pendPc <= fetchPc;
    end
  end

`ifdef IFETCH_PERF_EN
  // Only words actually written into the buffer count as fetched
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pushEn)     perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!out_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Testbench for ifetch_unit: memory model, expected-PC scoreboard and protocol monitor.
// Works with and without IFETCH_PERF_EN.
module tb_ifetch_unit;

  localparam int          AW       = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt    = 1'b0;
  logic          imem_rvalid = 1'b0;
  logic [31:0]   imem_rdata  = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc    = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc4;
`ifdef IFETCH_PERF_EN
  logic [31:0]   perfFetchCnt;
  logic [31:0]   perfStallCnt;
`endif

  int testsRun    = 0;
  int testsFailed = 0;

  // memory model knobs and state
  int          gntProb  = 100;
  int          latMin   = 1;
  int          latMax   = 1;
  int          gntDelay = 0;
  bit          memBusy  = 0;
  int          memCnt   = 0;
  logic [31:0] memAddr  = '0;
  int          reqAge   = 0;
  int          lastAge  = 0;
  int          gntCount = 0;
  logic [31:0] salt     = '0;

  // scoreboard: expected PCs of upcoming output transfers
  logic [31:0] expQ [$];
  int          popCount   = 0;
  int          stallModel = 0;

  always #5 clk = ~clk;

  ifetch_unit #(
    .ADDR_WIDTH(AW),
    .RESET_PC  (RESET_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pc4       (out_pc4)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetch_cnt(perfFetchCnt),
    .perf_stall_cnt(perfStallCnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of core-side inputs; a redirect restarts the expected PC stream
  task automatic applyStimulus(input logic ready, input logic redir, input logic [31:0] pc);
    out_ready      = ready;
    redirect_valid = redir;
    redirect_pc    = pc;
    if (redir) begin
      expQ.delete();
      expQ.push_back({pc[31:2], 2'b00});
    end
    @(posedge clk); #1;
  endtask

  task automatic resetDut(input logic [31:0] newSalt);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    salt           = newSalt;
    expQ.delete();
    expQ.push_back(RESET_PC);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    rst      = 1'b0;
    gntCount = 0;
  endtask

  task automatic waitValid(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin
        ok = 1;
        break;
      end
      applyStimulus(1'b0, 1'b0, 32'd0);
    end
    checkOutput(name, {31'b0, ok}, 32'd1);
  endtask

  // Instruction memory: grants with configurable probability/delay and returns
  // (address ^ salt) in order after 1..N cycles.
  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (rst) begin
      memBusy = 0;
      reqAge  = 0;
    end else begin
      if (memBusy) begin
        if (memCnt <= 1) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memAddr ^ salt;
          memBusy     = 0;
        end else begin
          memCnt--;
        end
      end
      if (imem_req) begin
        if (reqAge >= gntDelay && $urandom_range(99) < gntProb) begin
          checkOutput("single_outstanding", {31'b0, memBusy}, 32'd0);
          imem_gnt = 1'b1;
          memBusy  = 1;
          memAddr  = imem_addr;
          memCnt   = $urandom_range(latMax, latMin);
          lastAge  = reqAge;
          reqAge   = 0;
          gntCount++;
        end else begin
          reqAge++;
        end
      end else begin
        reqAge = 0;
      end
    end
  end

  // Monitor: protocol stability checks and scoreboard comparison on every transfer
  logic        pReq = 0, pGnt = 0, pValid = 0, pReady = 0, pRedir = 0, pRst = 1;
  logic [31:0] pAddr = '0, pInstr = '0, pPc = '0;

  always @(negedge clk) begin
    logic [31:0] exp;
    #1;
    if (!rst) begin
      if (pReq && !pGnt && !pRedir && !pRst) begin
        checkOutput("req_held", {31'b0, imem_req}, 32'd1);
        checkOutput("addr_held", imem_addr, pAddr);
      end
      if (pValid && !pReady && !pRedir && !pRst) begin
        checkOutput("valid_held", {31'b0, out_valid}, 32'd1);
        checkOutput("instr_held", out_instr, pInstr);
        checkOutput("pc_held", out_pc, pPc);
      end
      if (imem_req) checkOutput("addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
      if (out_valid && out_ready && !redirect_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("scoreboard_empty", out_pc, 32'hDEAD_BEEF);
        end else begin
          exp = expQ.pop_front();
          checkOutput("out_pc", out_pc, exp);
          checkOutput("out_instr", out_instr, exp ^ salt);
          checkOutput("out_pc4", out_pc4, exp + 32'd4);
          if (expQ.size() == 0) expQ.push_back(exp + 32'd4);
          popCount++;
        end
      end
`ifdef IFETCH_PERF_EN
      checkOutput("perf_stall", perfStallCnt, stallModel);
`endif
      if (!out_valid) stallModel++;
    end else begin
      stallModel = 0;
    end
    pReq   = imem_req;
    pGnt   = imem_gnt;
    pAddr  = imem_addr;
    pValid = out_valid;
    pReady = out_ready;
    pInstr = out_instr;
    pPc    = out_pc;
    pRedir = redirect_valid;
    pRst   = rst;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int popsBefore;
    bit found;

    @(posedge clk); #1;
    resetDut(32'd0);

    // in-order sequential fetch and first-output latency
    out_ready = 1'b1;
    lat = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #2;
      if (out_valid && lat < 0) lat = c;
    end
    @(posedge clk); #1;
    checkOutput("first_latency", lat, 32'd2);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("seq_progress", {31'b0, (popCount >= 6)}, 32'd1);

    // buffer fills to exactly DEPTH and then stops requesting
    resetDut(32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("full_grants", gntCount, DEPTH);
    checkOutput("full_req_low", {31'b0, imem_req}, 32'd0);
    checkOutput("full_valid", {31'b0, out_valid}, 32'd1);
`ifdef IFETCH_PERF_EN
    checkOutput("perf_fetch_full", perfFetchCnt, DEPTH);
`endif
    out_ready = 1'b1;
    #1;
    checkOutput("resume_req", {31'b0, imem_req}, 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // redirect while a slow response is outstanding
    latMin = 3;
    latMax = 3;
    found  = 0;
    for (int i = 0; i < 20; i++) begin
      if (memBusy && memCnt == 3) begin
        found = 1;
        break;
      end
      applyStimulus(1'b1, 1'b0, 32'd0);
    end
    checkOutput("wait_state_seen", {31'b0, found}, 32'd1);
    applyStimulus(1'b1, 1'b1, 32'h40);
    waitValid("redir40_timeout");
    checkOutput("redir40_pc", out_pc, 32'h40);
    checkOutput("redir40_pc4", out_pc4, 32'h44);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // unaligned target is aligned; redirect and pop in the same cycle
    latMin = 1;
    latMax = 1;
    applyStimulus(1'b0, 1'b1, 32'h103);
    checkOutput("redir_align_addr", imem_addr, 32'h100);
    waitValid("redir103_timeout");
    checkOutput("redir103_pc", out_pc, 32'h100);
    applyStimulus(1'b1, 1'b1, 32'h200);
    checkOutput("flush_pop_valid", {31'b0, out_valid}, 32'd0);

    // delayed grant: request must sit stable for three cycles
    gntDelay = 3;
    for (int i = 0; i < 24; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("gnt_delay_age", lastAge, 32'd3);
    gntDelay = 0;

    // address wrap at the top of the space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    waitValid("wrap_timeout");
    checkOutput("wrap_pc", out_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", out_pc4, 32'h0000_0000);
    popsBefore = popCount;
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("wrap_progress", {31'b0, (popCount >= popsBefore + 3)}, 32'd1);

    // randomized traffic: ready, grant, latency, redirects and occasional resets
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) begin
        gntProb = $urandom_range(100, 30);
        latMin  = 1;
        latMax  = $urandom_range(4, 1);
      end
      if ($urandom_range(999) < 3) begin
        resetDut($urandom);
      end else begin
        applyStimulus($urandom_range(99) < 70, $urandom_range(99) < 4, $urandom);
      end
    end
    checkOutput("random_progress", {31'b0, (popCount > 300)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
